// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative restoring divider for DIV / DIVU.
//
// A start pulse accepted in IDLE latches the operands. CALC then runs one
// shift-subtract step per cycle for N cycles, producing quotient bits
// MSB-first. FINISH raises done for one cycle and presents
// {remainder, quotient} in the same HI/LO layout as the multiply result.
// A zero divisor skips CALC and returns {dividend, all ones} with div_zero set.
//
// Ports:
//   clk, resetn    rising-edge clock, asynchronous active-low reset
//   start          request; only looked at in IDLE
//   signed_div     1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend       N-bit rs operand, sampled when start is accepted
//   divisor        N-bit rt operand, sampled when start is accepted
//   cancel         flush/exception; aborts the operation without done
//   busy           high during CALC; the execute stage stalls on it
//   done           one-cycle result-valid pulse
//   div_zero       divisor was zero for the completing operation
//   result         {remainder (HI), quotient (LO)}, held until the next done
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic           signed_div,
   input  logic [N-1:0]   dividend,
   input  logic [N-1:0]   divisor,
   input  logic           cancel,
   output logic           busy,
   output logic           done,
   output logic           div_zero,
   output logic [2*N-1:0] result
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} stateT;

   stateT           state, nextState;
   logic [CW-1:0]   count;
   logic [N-1:0]    quoReg;      // dividend magnitude shifts out as quotient shifts in
   logic [N-1:0]    remReg;
   logic [N-1:0]    divMag;
   logic [N-1:0]    dividendRaw; // kept for the divide-by-zero remainder
   logic            negQuo;
   logic            negRem;
   logic            zeroDiv;
   logic [2*N-1:0]  resultReg;
   logic            divZeroReg;

   logic [N:0]      shifted;
   logic [N-1:0]    remTrial;
   logic            fits;
   logic [2*N-1:0]  finalResult;

   // Magnitude of an operand; the most negative value maps onto itself,
   // which read as unsigned is the correct magnitude.
   function automatic logic [N-1:0] magnitude(input logic isSigned, input logic [N-1:0] v);
      logic signed [N-1:0] sv;
      sv = signed'(v);
      return (isSigned && sv < 0) ? N'(-sv) : v;
   endfunction

   function automatic logic [N-1:0] applySign(input logic neg, input logic [N-1:0] v);
      logic signed [N-1:0] sv;
      sv = signed'(v);
      return neg ? N'(-sv) : v;
   endfunction

   // Restoring step: bring down the next dividend bit, subtract if it fits.
   always_comb begin
      shifted  = {remReg, quoReg[N-1]};
      fits     = shifted >= {1'b0, divMag};
      remTrial = N'(shifted - {1'b0, divMag});
   end

   always_comb begin
      if (zeroDiv)
         finalResult = {dividendRaw, {N{1'b1}}};
      else
         finalResult = {applySign(negRem, remReg), applySign(negQuo, quoReg)};
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start && !cancel)
               nextState = (divisor == '0) ? FINISH : CALC;
         end
         CALC: begin
            if (cancel)
               nextState = IDLE;
            else if (count == CW'(N-1))
               nextState = FINISH;
         end
         FINISH:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand capture, iteration and result capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count       <= '0;
         quoReg      <= '0;
         remReg      <= '0;
         divMag      <= '0;
         dividendRaw <= '0;
         negQuo      <= 1'b0;
         negRem      <= 1'b0;
         zeroDiv     <= 1'b0;
         resultReg   <= '0;
         divZeroReg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  count       <= '0;
                  quoReg      <= magnitude(signed_div, dividend);
                  remReg      <= '0;
                  divMag      <= magnitude(signed_div, divisor);
                  dividendRaw <= dividend;
                  negQuo      <= signed_div & (dividend[N-1] ^ divisor[N-1]);
                  negRem      <= signed_div & dividend[N-1];
                  zeroDiv     <= (divisor == '0);
               end
            end
            CALC: begin
               if (!cancel) begin
                  count  <= count + 1'b1;
                  remReg <= fits ? remTrial : shifted[N-1:0];
                  quoReg <= {quoReg[N-2:0], fits};
               end
            end
            FINISH: begin
               if (!cancel) begin
                  resultReg  <= finalResult;
                  divZeroReg <= zeroDiv;
               end
            end
            default: ;
         endcase
      end
   end

   // The result is presented during the done cycle and held afterwards;
   // a cancel in FINISH suppresses both done and the register update.
   always_comb begin
      busy     = (state == CALC);
      done     = (state == FINISH) && !cancel;
      result   = done ? finalResult : resultReg;
      div_zero = done ? zeroDiv : divZeroReg;
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        signedDiv;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        cancel;
   logic        busy;
   logic        done;
   logic        divZero;
   logic [63:0] result;

   int          nAsserts = 0;
   int          nFails   = 0;
   logic [63:0] lastExp  = '0;
   logic        lastDz   = 1'b0;

   div_unit #(.N(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .signed_div (signedDiv),
      .dividend   (dividend),
      .divisor    (divisor),
      .cancel     (cancel),
      .busy       (busy),
      .done       (done),
      .div_zero   (divZero),
      .result     (result)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division. Zero divisor gives {dividend, all ones};
   // signed uses 64-bit truncating division, then keeps the low 32 bits.
   function automatic logic [63:0] refDiv(input logic sd, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!sd) return {a % b, a / b};
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Call #1 after a rising edge (that cycle is cycle 0). Optionally pulses a
   // stray start in cycle pulseCyc, which must be ignored.
   task automatic runOp(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input int pulseCyc);
      logic [63:0] exp;
      logic [63:0] resAt;
      logic        dzAt;
      int          expCyc, doneCyc, nDone, busyBad;
      exp    = refDiv(sd, a, b);
      expCyc = (b == 32'd0) ? 1 : 33;
      signedDiv = sd; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = $urandom; divisor = $urandom; signedDiv = 1'($urandom_range(0, 1));
      doneCyc = 0; nDone = 0; busyBad = 0; resAt = '0; dzAt = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (busy !== ((b != 32'd0) && cyc <= 32)) busyBad++;
         if (done === 1'b1) begin
            nDone++;
            if (doneCyc == 0) begin
               doneCyc = cyc; resAt = result; dzAt = divZero;
            end
         end else if (done !== 1'b0) busyBad++;
         start = (cyc == pulseCyc);
      end
      @(posedge clk); #1;
      check({tag, ".doneCycle"}, 64'(doneCyc), 64'(expCyc));
      check({tag, ".doneCount"}, 64'(nDone), 64'd1);
      check({tag, ".busyProfile"}, 64'(busyBad), 64'd0);
      check({tag, ".result"}, resAt, exp);
      check({tag, ".divZero"}, 64'(dzAt), 64'(b == 32'd0));
      check({tag, ".resultHeld"}, result, exp);
      lastExp = exp;
      lastDz  = (b == 32'd0);
   endtask

   initial begin
      logic [63:0] exp;
      logic [31:0] ra, rb;
      logic        rs;
      int          d1, d2;

      resetn = 1'b0; start = 1'b0; signedDiv = 1'b0; cancel = 1'b0;
      dividend = '0; divisor = '0;
      #1;
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.result", result, 64'd0);
      check("reset.divZero", 64'(divZero), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      runOp("u100div7", 1'b0, 32'd100, 32'd7, 0);
      check("u100div7.literal", lastExp, 64'h00000002_0000000E);
      runOp("sNeg7div2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      check("sNeg7div2.literal", lastExp, 64'hFFFFFFFF_FFFFFFFD);
      runOp("s7divNeg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      check("s7divNeg2.literal", lastExp, 64'h00000001_FFFFFFFD);
      runOp("sOverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("sOverflow.literal", lastExp, 64'h00000000_80000000);
      runOp("uMaxDiv1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
      runOp("uMaxDivMax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("uMaxDivMax.literal", lastExp, 64'h00000000_00000001);
      runOp("s5div0", 1'b1, 32'd5, 32'd0, 0);
      check("s5div0.literal", lastExp, 64'h00000005_FFFFFFFF);
      runOp("u5div0", 1'b0, 32'd5, 32'd0, 0);
      runOp("sNegDiv0", 1'b1, 32'hFFFF_FFF0, 32'd0, 0);

      // Stray start while busy and during the done cycle
      runOp("pulseBusy", 1'b0, 32'd123456, 32'd789, 5);
      runOp("pulseFinish", 1'b1, 32'hFFFF_0000, 32'd13, 33);

      // Cancel in cycle 10, restart in cycle 11
      signedDiv = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      cancel = 1'b1;
      @(negedge clk);
      check("cancel.busyInCycle10", 64'(busy), 64'd1);
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      check("cancel.busyAfter", 64'(busy), 64'd0);
      check("cancel.noDone", 64'(done), 64'd0);
      check("cancel.resultKept", result, lastExp);
      check("cancel.divZeroKept", 64'(divZero), 64'(lastDz));
      runOp("cancelRestart", 1'b1, 32'hFFFF_FF00, 32'd7, 0);

      // Cancel together with start in IDLE
      signedDiv = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      check("idleCancel.busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("idleCancel.done", 64'(done), 64'd0);
      @(posedge clk); #1;

      // Start held high: re-accepted the cycle after done
      signedDiv = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7; start = 1'b1;
      exp = refDiv(1'b1, 32'hFFFF_FF9C, 32'd7);
      @(posedge clk); #1;
      d1 = 0; d2 = 0;
      for (int cyc = 1; cyc <= 67; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (d1 == 0) d1 = cyc;
            else if (d2 == 0) d2 = cyc;
         end
         if (cyc == 67) start = 1'b0;
      end
      check("holdStart.result", result, exp);
      @(posedge clk); #1;
      check("holdStart.firstDone", 64'(d1), 64'd33);
      check("holdStart.secondDone", 64'(d2), 64'd67);

      // Asynchronous reset in the middle of an operation
      signedDiv = 1'b0; dividend = 32'd50000; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      #2 resetn = 1'b0;
      #1;
      check("midReset.busy", 64'(busy), 64'd0);
      check("midReset.done", 64'(done), 64'd0);
      check("midReset.result", result, 64'd0);
      check("midReset.divZero", 64'(divZero), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      runOp("postReset9div3", 1'b0, 32'd9, 32'd3, 0);
      check("postReset9div3.literal", lastExp, 64'h00000000_00000003);

      // Randomized operations against the reference model
      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = $urandom;
            default: rb = 32'd0 - 32'($urandom_range(1, 15));
         endcase
         runOp($sformatf("rand%0d", i), rs, ra, rb, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
